// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the sum accumulator and its saturating stages.
// Default widths match the multi-adder outputs feeding this block.
package sum_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEF_SW   = 9;
   localparam int DEF_ACCW = 12;
   localparam int DEF_LENW = 8;

   function automatic longint unsigned acc_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   localparam longint unsigned ACC_MAX = acc_max(DEF_ACCW);

   // The accumulator must hold at least one full pair sum without loss.
   function automatic bit acc_cfg_ok(input int sw, input int accw);
      return accw >= sw + 1;
   endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Frame control, input beat and result ports of the sum accumulator.
// The master side drives the inputs; the slave side is the accumulator.
interface sum_accumulator_if #(
   parameter int SW   = 9,
   parameter int ACCW = 12,
   parameter int LENW = 8
);
   logic            start;
   logic [LENW-1:0] frame_len;
   logic            len_err;
   logic            busy;
   logic            in_valid;
   logic            in_ready;
   logic [SW-1:0]   sum0;
   logic [SW-1:0]   sum1;
   logic            out_valid;
   logic            out_ready;
   logic [ACCW-1:0] out_acc;
   logic            out_sat;
   logic [LENW-1:0] out_count;

   modport master (
      output start, frame_len, in_valid, sum0, sum1, out_ready,
      input  len_err, busy, in_ready, out_valid, out_acc, out_sat, out_count
   );

   modport slave (
      input  start, frame_len, in_valid, sum0, sum1, out_ready,
      output len_err, busy, in_ready, out_valid, out_acc, out_sat, out_count
   );
endinterface

// File: rtl/sum_accumulator_sat_add.sv
// Combinational saturating adder: acc + pair clipped at MAX, with overflow flag.
// pair must be no wider than acc.
module sat_add #(
   parameter int            AW  = 12,
   parameter int            PW  = 10,
   parameter logic [AW-1:0] MAX = '1
) (
   input  logic [AW-1:0] acc,
   input  logic [PW-1:0] pair,
   output logic [AW-1:0] sum_sat,
   output logic          ovf
);
   logic [AW:0] sum_full;

   assign sum_full = {1'b0, acc} + (AW+1)'(pair);
   assign ovf      = sum_full > {1'b0, MAX};
   assign sum_sat  = ovf ? MAX : sum_full[AW-1:0];
endmodule

// File: rtl/sum_accumulator.sv
// Accumulates sum0+sum1 over a programmable frame of accepted beats with
// saturation, then holds the frame total until the consumer takes it.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int SW   = DEF_SW,
   parameter int ACCW = DEF_ACCW,
   parameter int LENW = DEF_LENW
) (
   input  logic               clk,
   input  logic               rst_n,
   sum_accumulator_if.slave   bus
);
   if (!acc_cfg_ok(SW, ACCW)) begin : g_cfg_err
      $error("sum_accumulator: ACCW must be at least SW+1");
   end

   localparam logic [ACCW-1:0] ACC_LIMIT = ACCW'(acc_max(ACCW));

   state_e          state_q, state_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [LENW-1:0] remaining_q, remaining_d;
   logic [LENW-1:0] count_q, count_d;
   logic            sat_q, sat_d;
   logic [ACCW-1:0] out_acc_q, out_acc_d;
   logic            out_sat_q, out_sat_d;
   logic [LENW-1:0] out_count_q, out_count_d;
   logic            len_err_q, len_err_d;

   logic [SW:0]     pair;
   logic [ACCW-1:0] acc_sum;
   logic            acc_ovf;

   assign pair = (SW+1)'(bus.sum0) + (SW+1)'(bus.sum1);

   sat_add #(
      .AW  (ACCW),
      .PW  (SW + 1),
      .MAX (ACC_LIMIT)
   ) u_sat_add (
      .acc     (acc_q),
      .pair    (pair),
      .sum_sat (acc_sum),
      .ovf     (acc_ovf)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      remaining_d = remaining_q;
      count_d     = count_q;
      sat_d       = sat_q;
      out_acc_d   = out_acc_q;
      out_sat_d   = out_sat_q;
      out_count_d = out_count_q;
      len_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.frame_len != '0) begin
                  state_d     = ACCUM;
                  remaining_d = bus.frame_len;
                  acc_d       = '0;
                  sat_d       = 1'b0;
                  count_d     = '0;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               acc_d       = acc_sum;
               sat_d       = sat_q | acc_ovf;
               count_d     = count_q + LENW'(1);
               remaining_d = remaining_q - LENW'(1);
               if (remaining_q == LENW'(1)) begin
                  state_d     = DONE;
                  out_acc_d   = acc_sum;
                  out_sat_d   = sat_q | acc_ovf;
                  out_count_d = count_q + LENW'(1);
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               // A start on the handshake cycle chains the next frame directly.
               if (bus.start && bus.frame_len != '0) begin
                  state_d     = ACCUM;
                  remaining_d = bus.frame_len;
                  acc_d       = '0;
                  sat_d       = 1'b0;
                  count_d     = '0;
               end else if (bus.start) begin
                  len_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         remaining_q <= '0;
         count_q     <= '0;
         sat_q       <= 1'b0;
         out_acc_q   <= '0;
         out_sat_q   <= 1'b0;
         out_count_q <= '0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         remaining_q <= remaining_d;
         count_q     <= count_d;
         sat_q       <= sat_d;
         out_acc_q   <= out_acc_d;
         out_sat_q   <= out_sat_d;
         out_count_q <= out_count_d;
         len_err_q   <= len_err_d;
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.len_err   = len_err_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.out_count = out_count_q;
endmodule
